wtm_seq: RTL and testbench

WTM_SEQ -- requirements
Module: wtm_seq

---
 rtl/wtm_pkg.sv | 22 ++
 rtl/wtm.sv | 46 ++++
 rtl/wtm_seq.sv | 149 ++++++++++++++
 tb/tb_wtm_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/wtm_pkg.sv
// Shared types and constants for the sequential 10x10 multiplier built on the 5x5 wtm.
// Optional feature macro: WTM_SEQ_ZERO_SKIP_EN (zero-operand fast path in wtm_seq).
package wtm_pkg;

    localparam int unsigned HALF_W = 5;
    localparam int unsigned OP_W   = 10;
    localparam int unsigned PROD_W = 20;

    localparam logic [3:0] SHIFT_LO  = 4'd0;
    localparam logic [3:0] SHIFT_MID = 4'd5;
    localparam logic [3:0] SHIFT_HI  = 4'd10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/wtm.sv
// 5x5 unsigned Wallace-tree multiplier: partial products reduced by 3:2 compressors,
// then one carry-propagate add. cout is always 0 for 5-bit operands.
module wtm
    import wtm_pkg::*;
(
    input  logic [HALF_W-1:0]   x,
    input  logic [HALF_W-1:0]   y,
    output logic [2*HALF_W-1:0] p,
    output logic                cout
);

    function automatic logic [2*HALF_W-1:0] csa_sum(input logic [2*HALF_W-1:0] u,
                                                     input logic [2*HALF_W-1:0] v,
                                                     input logic [2*HALF_W-1:0] w);
        return u ^ v ^ w;
    endfunction

    function automatic logic [2*HALF_W-1:0] csa_carry(input logic [2*HALF_W-1:0] u,
                                                       input logic [2*HALF_W-1:0] v,
                                                       input logic [2*HALF_W-1:0] w);
        logic [2*HALF_W-1:0] maj;
        maj = (u & v) | (u & w) | (v & w);
        return {maj[2*HALF_W-2:0], 1'b0};
    endfunction

    logic [2*HALF_W-1:0] pp_s [HALF_W];
    logic [2*HALF_W-1:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s;
    logic [2*HALF_W:0]   sum_s;

    // Partial-product generation, three compressor layers, final adder
    always_comb begin
        for (int i = 0; i < HALF_W; i++) begin
            pp_s[i] = {{HALF_W{1'b0}}, x & {HALF_W{y[i]}}} << i;
        end
        s0_s  = csa_sum(pp_s[0], pp_s[1], pp_s[2]);
        c0_s  = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
        s1_s  = csa_sum(s0_s, c0_s, pp_s[3]);
        c1_s  = csa_carry(s0_s, c0_s, pp_s[3]);
        s2_s  = csa_sum(s1_s, c1_s, pp_s[4]);
        c2_s  = csa_carry(s1_s, c1_s, pp_s[4]);
        sum_s = {1'b0, s2_s} + {1'b0, c2_s};
        p     = sum_s[2*HALF_W-1:0];
        cout  = sum_s[2*HALF_W];
    end

endmodule

// File: rtl/wtm_seq.sv
// Sequential 10x10 unsigned multiplier time-sharing one 5x5 wtm over four partial products.
// Define WTM_SEQ_ZERO_SKIP_EN to send zero-operand requests straight to DONE.
module wtm_seq
    import wtm_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t              state_r;
    logic [OP_W-1:0]     a_r, b_r;
    logic [PROD_W-1:0]   acc_r;
    logic                in_ready_r, out_valid_r, busy_r;

    logic [HALF_W-1:0]   mx_a_s, mx_b_s;
    logic [3:0]          shift_s;
    logic [2*HALF_W-1:0] pp_s;
    logic                unused_cout_s;
    logic [PROD_W-1:0]   term_s;
    logic                hs_s;

    wtm u_wtm (
        .x    (mx_a_s),
        .y    (mx_b_s),
        .p    (pp_s),
        .cout (unused_cout_s)
    );

    // Select the operand halves and weight for the partial product of the current phase
    always_comb begin
        mx_a_s  = '0;
        mx_b_s  = '0;
        shift_s = SHIFT_LO;
        case (state_r)
            P0: begin
                mx_a_s  = a_r[HALF_W-1:0];
                mx_b_s  = b_r[HALF_W-1:0];
                shift_s = SHIFT_LO;
            end
            P1: begin
                mx_a_s  = a_r[OP_W-1:HALF_W];
                mx_b_s  = b_r[HALF_W-1:0];
                shift_s = SHIFT_MID;
            end
            P2: begin
                mx_a_s  = a_r[HALF_W-1:0];
                mx_b_s  = b_r[OP_W-1:HALF_W];
                shift_s = SHIFT_MID;
            end
            P3: begin
                mx_a_s  = a_r[OP_W-1:HALF_W];
                mx_b_s  = b_r[OP_W-1:HALF_W];
                shift_s = SHIFT_HI;
            end
            default: begin
                mx_a_s  = '0;
                mx_b_s  = '0;
                shift_s = SHIFT_LO;
            end
        endcase
        term_s = {{(PROD_W-2*HALF_W){1'b0}}, pp_s} << shift_s;
        hs_s   = in_valid && in_ready_r;
    end

    // Sequencer, operand capture, accumulator and registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs_s) begin
                        a_r        <= a;
                        b_r        <= b;
                        acc_r      <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef WTM_SEQ_ZERO_SKIP_EN
                        if ((a == 10'd0) || (b == 10'd0)) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= P0;
                        end
`else
                        state_r <= P0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                P0: begin
                    acc_r   <= acc_r + term_s;
                    state_r <= P1;
                end
                P1: begin
                    acc_r   <= acc_r + term_s;
                    state_r <= P2;
                end
                P2: begin
                    acc_r   <= acc_r + term_s;
                    state_r <= P3;
                end
                P3: begin
                    acc_r       <= acc_r + term_s;
                    state_r     <= DONE;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    // Product stays parked until the consumer takes it
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = acc_r;

endmodule

// File: tb/tb_wtm_seq.sv
// Directed self-checking bench for wtm_seq; expected products are hand-computed constants.
module tb_wtm_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  a = 10'd0;
    logic [9:0]  b = 10'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] product;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef WTM_SEQ_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 5;
`endif

    wtm_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: handshake, latency measurement, hold in DONE, release
    task automatic do_op(input string tag, input logic [9:0] av, input logic [9:0] bv,
                         input logic [19:0] exp_p, input int exp_lat, input int hold);
        int  lat;
        bit  ready_low;
        bit  stable;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        a = av; b = bv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~av; b = ~bv;
        lat = 1;
        ready_low = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) ready_low = 1'b0;
            step();
            lat++;
        end
        if (in_ready) ready_low = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prod"}, {12'd0, product}, {12'd0, exp_p});
        check({tag, "_rdylow"}, {31'd0, ready_low}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!out_valid || product !== exp_p) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [19:0] expq [$];
        int          last_c;
        int          n_out;
        logic [9:0]  av, bv;
        bit          seen;

        step();
        step();
        reset = 1'b0;
        check("rst_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        check("rst_prod", {12'd0, product}, 32'd0);

        do_op("m12x13", 10'd12, 10'd13, 20'd156, 5, 0);
        do_op("m1023sq", 10'd1023, 10'd1023, 20'd1046529, 5, 0);
        do_op("m0x777", 10'd0, 10'd777, 20'd0, ZERO_LAT, 0);
        do_op("m555x0", 10'd555, 10'd0, 20'd0, ZERO_LAT, 0);
        do_op("m18x3", 10'd18, 10'd3, 20'd54, 5, 3);
        do_op("m31x31", 10'd31, 10'd31, 20'd961, 5, 0);
        do_op("m32x32", 10'd32, 10'd32, 20'd1024, 5, 0);
        do_op("m1000x999", 10'd1000, 10'd999, 20'd999000, 5, 1);

        // Reset while in P2 discards the operation
        a = 10'd100; b = 10'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstp2_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("rstp2_noval", {31'd0, seen}, 32'd0);
        do_op("m5x6", 10'd5, 10'd6, 20'd30, 5, 0);

        // Reset wins over a simultaneous handshake
        a = 10'd7; b = 10'd9; in_valid = 1'b1; reset = 1'b1;
        step();
        in_valid = 1'b0; reset = 1'b0;
        check("rst_vs_hs", {29'd0, out_valid, in_ready, busy}, 32'b010);

        // in_valid held high with operands changing every cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_c = -1;
        n_out  = 0;
        for (int c = 0; c < 18; c++) begin
            av = 10'(c * 37 + 3);
            bv = 10'(c * 11 + 1);
            a = av; b = bv;
            if (in_ready) expq.push_back(20'(av * bv));
            step();
            if (out_valid) begin
                if (expq.size() == 0) check("stream_extra", 32'd1, 32'd0);
                else check("stream_prod", {12'd0, product}, {12'd0, expq.pop_front()});
                if (last_c >= 0) check("stream_gap", c - last_c, 32'd6);
                last_c = c;
                n_out++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", n_out, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
